// File: rtl/shift_exec_stage_pkg.sv
// -----------------------------------------------------------------------------
// shift_exec_stage_pkg
// Shared types for the shift execute stage: the shift-op encoding seen on
// i_op and the state encoding of the two-entry output skid buffer.
// No ports (package).
// -----------------------------------------------------------------------------
package shift_exec_stage_pkg;

    localparam int DATA_W = 32;
    localparam int AMT_W  = 5;   // only the low five amount bits are significant

    typedef enum logic [1:0] {
        OP_SLL  = 2'b00,
        OP_SRL  = 2'b01,
        OP_SRA  = 2'b10,
        OP_RSVD = 2'b11
    } shift_op_e;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'b00,
        SKID_ONE   = 2'b01,
        SKID_FULL  = 2'b10
    } skid_state_e;

endpackage

// File: rtl/shift_exec_stage_shifter.sv
// -----------------------------------------------------------------------------
// shift_exec_stage_shifter
// Single-direction barrel shifter. SHIFT_DIR = 0 shifts left, SHIFT_DIR = 1
// shifts right. The bits vacated by the shift are filled with i_sext & msb,
// so a right shifter with i_sext = 1 performs an arithmetic shift.
// Ports:
//   i_data   [DATA_W-1:0]  operand
//   i_amount [AMT_W-1:0]   shift distance
//   i_sext                 fill vacated bits with the operand sign bit
//   o_data   [DATA_W-1:0]  shifted result
// -----------------------------------------------------------------------------
module shift_exec_stage_shifter
    import shift_exec_stage_pkg::*;
#(
    parameter bit SHIFT_DIR = 1'b0
) (
    input  logic [DATA_W-1:0] i_data,
    input  logic [AMT_W-1:0]  i_amount,
    input  logic              i_sext,
    output logic [DATA_W-1:0] o_data
);

    function automatic logic [DATA_W-1:0] bit_reverse(input logic [DATA_W-1:0] v);
        logic [DATA_W-1:0] r;
        for (int i = 0; i < DATA_W; i++) begin
            r[i] = v[DATA_W-1-i];
        end
        return r;
    endfunction

    logic              fill;
    logic [DATA_W-1:0] oper;
    logic [DATA_W-1:0] fill_mask;
    logic [DATA_W-1:0] shifted;

    // A right shift is a left shift of the bit-reversed operand, so one
    // left-shift core serves both directions.
    assign fill      = i_sext & i_data[DATA_W-1];
    assign oper      = SHIFT_DIR ? bit_reverse(i_data) : i_data;
    assign fill_mask = ~({DATA_W{1'b1}} << i_amount);
    assign shifted   = (oper << i_amount) | (fill ? fill_mask : '0);
    assign o_data    = SHIFT_DIR ? bit_reverse(shifted) : shifted;

endmodule

// File: rtl/shift_exec_stage.sv
// -----------------------------------------------------------------------------
// shift_exec_stage
// Execute stage for SLL/SRL/SRA with a two-entry output skid buffer.
// A shift accepted on cycle N is presented on cycle N+1; results leave in
// order. o_ready is registered and has no combinational path from i_ready.
// Optional feature macro: SHIFT_EXEC_STALL_CNT_EN adds o_stall_cnt, a
// saturating count of cycles with o_valid && !i_ready (cleared only by i_rst).
// Ports:
//   i_clk, i_rst (sync, active-high), i_flush (drops all entries + input op)
//   i_valid/o_ready, i_op[1:0], i_data[31:0], i_amount[5:0], i_rd[RD_W-1:0]
//   o_valid/i_ready, o_data[31:0], o_rd[RD_W-1:0], o_illegal
//   o_stall_cnt[31:0] (only with SHIFT_EXEC_STALL_CNT_EN)
// -----------------------------------------------------------------------------
module shift_exec_stage
    import shift_exec_stage_pkg::*;
#(
    parameter int RD_W = 5
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_flush,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [1:0]        i_op,
    input  logic [DATA_W-1:0] i_data,
    input  logic [5:0]        i_amount,
    input  logic [RD_W-1:0]   i_rd,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,
    output logic [RD_W-1:0]   o_rd,
    output logic              o_illegal
`ifdef SHIFT_EXEC_STALL_CNT_EN
    ,
    output logic [31:0]       o_stall_cnt
`endif
);

    shift_op_e         op;
    logic              amt_msb_unused;
    logic [DATA_W-1:0] left_res;
    logic [DATA_W-1:0] right_res;
    logic [DATA_W-1:0] res_data_p0;
    logic              res_ill_p0;
    logic              vld_p0;
    logic              dn_xfer;

    skid_state_e       state_q, state_d;
    logic              ready_q, ready_d;
    logic              ld_e0_res, ld_e0_fwd, ld_e1_res;

    logic [DATA_W-1:0] e0_data_q, e1_data_q;
    logic [RD_W-1:0]   e0_rd_q,   e1_rd_q;
    logic              e0_ill_q,  e1_ill_q;

    assign op             = shift_op_e'(i_op);
    assign amt_msb_unused = i_amount[5];

    shift_exec_stage_shifter #(.SHIFT_DIR(1'b0)) u_shift_left (
        .i_data   (i_data),
        .i_amount (i_amount[AMT_W-1:0]),
        .i_sext   (1'b0),
        .o_data   (left_res)
    );

    shift_exec_stage_shifter #(.SHIFT_DIR(1'b1)) u_shift_right (
        .i_data   (i_data),
        .i_amount (i_amount[AMT_W-1:0]),
        .i_sext   (op == OP_SRA),
        .o_data   (right_res)
    );

    always_comb begin
        res_data_p0 = '0;
        res_ill_p0  = 1'b0;
        case (op)
            OP_SLL:          res_data_p0 = left_res;
            OP_SRL, OP_SRA:  res_data_p0 = right_res;
            default:         res_ill_p0  = 1'b1;
        endcase
    end

    assign vld_p0  = i_valid && ready_q;
    assign dn_xfer = (state_q != SKID_EMPTY) && i_ready;

    // Skid control: e0 always holds the oldest entry, e1 the younger one.
    always_comb begin
        state_d   = state_q;
        ld_e0_res = 1'b0;
        ld_e0_fwd = 1'b0;
        ld_e1_res = 1'b0;
        case (state_q)
            SKID_EMPTY: begin
                if (vld_p0) begin
                    ld_e0_res = 1'b1;
                    state_d   = SKID_ONE;
                end
            end
            SKID_ONE: begin
                if (vld_p0 && dn_xfer) begin
                    ld_e0_res = 1'b1;
                end else if (vld_p0) begin
                    ld_e1_res = 1'b1;
                    state_d   = SKID_FULL;
                end else if (dn_xfer) begin
                    state_d   = SKID_EMPTY;
                end
            end
            SKID_FULL: begin
                if (dn_xfer) begin
                    ld_e0_fwd = 1'b1;
                    state_d   = SKID_ONE;
                end
            end
            default: state_d = SKID_EMPTY;
        endcase
        if (i_flush) begin
            state_d   = SKID_EMPTY;
            ld_e0_res = 1'b0;
            ld_e0_fwd = 1'b0;
            ld_e1_res = 1'b0;
        end
    end

    assign ready_d = (state_d != SKID_FULL);

    // ---- stage p0 -> p1: buffer control ----
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= SKID_EMPTY;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
        end
    end

    // ---- stage p0 -> p1: buffer payload (qualified by state, so no reset) ----
    always_ff @(posedge i_clk) begin
        if (ld_e0_res) begin
            e0_data_q <= res_data_p0;
            e0_rd_q   <= i_rd;
            e0_ill_q  <= res_ill_p0;
        end else if (ld_e0_fwd) begin
            e0_data_q <= e1_data_q;
            e0_rd_q   <= e1_rd_q;
            e0_ill_q  <= e1_ill_q;
        end
        if (ld_e1_res) begin
            e1_data_q <= res_data_p0;
            e1_rd_q   <= i_rd;
            e1_ill_q  <= res_ill_p0;
        end
    end

    assign o_ready   = ready_q;
    assign o_valid   = (state_q != SKID_EMPTY);
    assign o_data    = o_valid ? e0_data_q : '0;
    assign o_rd      = o_valid ? e0_rd_q   : '0;
    assign o_illegal = o_valid ? e0_ill_q  : 1'b0;

`ifdef SHIFT_EXEC_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            stall_cnt_q <= '0;
        end else if (o_valid && !i_ready) begin
            stall_cnt_q <= sat_inc(stall_cnt_q);
        end
    end

    assign o_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_shift_exec_stage.sv
// -----------------------------------------------------------------------------
// tb_shift_exec_stage
// Self-checking bench: a queue-based reference model of the stage is compared
// against the DUT outputs on every falling edge, plus directed literal
// expectations and a randomized traffic phase.
// -----------------------------------------------------------------------------
module tb_shift_exec_stage;

    localparam int RD_W = 5;

    logic            i_clk = 1'b0;
    logic            i_rst, i_flush, i_valid, i_ready;
    logic            o_ready, o_valid, o_illegal;
    logic [1:0]      i_op;
    logic [31:0]     i_data, o_data;
    logic [5:0]      i_amount;
    logic [RD_W-1:0] i_rd, o_rd;
`ifdef SHIFT_EXEC_STALL_CNT_EN
    logic [31:0]     o_stall_cnt;
    logic [31:0]     mdl_stall;
`endif

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    typedef struct {
        logic [31:0]     data;
        logic [RD_W-1:0] rd;
        logic            ill;
    } item_t;

    item_t mdl_q[$];

    always #5 i_clk = ~i_clk;

    shift_exec_stage #(.RD_W(RD_W)) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_flush   (i_flush),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_op      (i_op),
        .i_data    (i_data),
        .i_amount  (i_amount),
        .i_rd      (i_rd),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_data    (o_data),
        .o_rd      (o_rd),
        .o_illegal (o_illegal)
`ifdef SHIFT_EXEC_STALL_CNT_EN
        ,
        .o_stall_cnt (o_stall_cnt)
`endif
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Expected result of one operation, from the arithmetic meaning of each op.
    function automatic item_t model_op(input logic [1:0] op, input logic [31:0] d,
                                       input logic [5:0] amt, input logic [RD_W-1:0] rd);
        item_t it;
        int    a;
        a      = int'(amt) % 32;
        it.rd  = rd;
        it.ill = 1'b0;
        case (op)
            2'd0: it.data = d << a;
            2'd1: it.data = d >> a;
            2'd2: begin
                it.data = d >> a;
                if (d[31]) it.data = it.data | ~(32'hFFFF_FFFF >> a);
            end
            default: begin
                it.data = 32'h0;
                it.ill  = 1'b1;
            end
        endcase
        return it;
    endfunction

    // Advance the model by one clock using the inputs present at the edge.
    task automatic model_step();
        bit up, dn;
        if (i_rst) begin
            mdl_q.delete();
`ifdef SHIFT_EXEC_STALL_CNT_EN
            mdl_stall = 32'h0;
`endif
        end else begin
`ifdef SHIFT_EXEC_STALL_CNT_EN
            if (mdl_q.size() > 0 && !i_ready && mdl_stall != 32'hFFFF_FFFF) mdl_stall++;
`endif
            if (i_flush) begin
                mdl_q.delete();
            end else begin
                up = i_valid && (mdl_q.size() < 2);
                dn = (mdl_q.size() > 0) && i_ready;
                if (dn) void'(mdl_q.pop_front());
                if (up) mdl_q.push_back(model_op(i_op, i_data, i_amount, i_rd));
            end
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        model_step();
        @(negedge i_clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] op, input logic [31:0] d,
                         input logic [5:0] amt, input logic [RD_W-1:0] rd);
        i_valid  = 1'b1;
        i_op     = op;
        i_data   = d;
        i_amount = amt;
        i_rd     = rd;
    endtask

    // Compare process: DUT outputs against the model on every falling edge.
    initial begin
        forever begin
            @(negedge i_clk);
            if (chk_en) begin
                chk("o_valid", 32'(o_valid), 32'(mdl_q.size() > 0));
                chk("o_ready", 32'(o_ready), 32'(mdl_q.size() < 2));
                chk("o_data", o_data, (mdl_q.size() > 0) ? mdl_q[0].data : 32'h0);
                chk("o_rd", 32'(o_rd), (mdl_q.size() > 0) ? 32'(mdl_q[0].rd) : 32'h0);
                chk("o_illegal", 32'(o_illegal), (mdl_q.size() > 0) ? 32'(mdl_q[0].ill) : 32'h0);
`ifdef SHIFT_EXEC_STALL_CNT_EN
                chk("o_stall_cnt", o_stall_cnt, mdl_stall);
`endif
            end
        end
    end

    initial begin
        i_rst = 1'b1; i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
        i_op = 2'd0; i_data = 32'h0; i_amount = 6'd0; i_rd = '0;
`ifdef SHIFT_EXEC_STALL_CNT_EN
        mdl_stall = 32'h0;
`endif
        tick();
        tick();
        chk_en = 1'b1;
        chk("rst_valid", 32'(o_valid), 32'h0);
        chk("rst_ready", 32'(o_ready), 32'h1);
        chk("rst_data", o_data, 32'h0);
        chk("rst_rd", 32'(o_rd), 32'h0);
        chk("rst_illegal", 32'(o_illegal), 32'h0);
        i_rst = 1'b0;

        // Single-op results and latency
        i_ready = 1'b1;
        drive(2'd0, 32'h0A0A_0A0A, 6'd4, 5'd3);
        tick();
        chk("sll_valid", 32'(o_valid), 32'h1);
        chk("sll_data", o_data, 32'hA0A0_A0A0);
        drive(2'd2, 32'hFA0A_0A0A, 6'd4, 5'd4);
        tick();
        chk("sra_data", o_data, 32'hFFA0_A0A0);
        drive(2'd1, 32'hFA0A_0A0A, 6'd4, 5'd5);
        tick();
        chk("srl_data", o_data, 32'h0FA0_A0A0);
        drive(2'd0, 32'h0000_0001, 6'd33, 5'd6);
        tick();
        chk("amt_bit5_ignored", o_data, 32'h0000_0002);
        drive(2'd3, 32'hDEAD_BEEF, 6'd7, 5'd9);
        tick();
        chk("rsvd_data", o_data, 32'h0);
        chk("rsvd_illegal", 32'(o_illegal), 32'h1);
        chk("rsvd_rd", 32'(o_rd), 32'd9);
        i_valid = 1'b0;
        tick();

        // Back-pressure: three ops with i_ready low, then drain in order
        i_ready = 1'b0;
        drive(2'd0, 32'd1, 6'd0, 5'd1);
        tick();
        chk("bp_ready_after1", 32'(o_ready), 32'h1);
        drive(2'd0, 32'd2, 6'd0, 5'd2);
        tick();
        chk("bp_ready_after2", 32'(o_ready), 32'h0);
        drive(2'd0, 32'd3, 6'd0, 5'd3);
        tick();
        chk("bp_hold_ready", 32'(o_ready), 32'h0);
        chk("bp_hold_data", o_data, 32'd1);
        i_ready = 1'b1;
        tick();
        chk("bp_second", o_data, 32'd2);
        tick();
        chk("bp_third", o_data, 32'd3);
        i_valid = 1'b0;
        tick();
        chk("bp_drained", 32'(o_valid), 32'h0);

        // Flush while FULL with a simultaneous upstream op
        i_ready = 1'b0;
        drive(2'd0, 32'h11, 6'd1, 5'd1);
        tick();
        drive(2'd0, 32'h22, 6'd1, 5'd2);
        tick();
        chk("fl_full_ready", 32'(o_ready), 32'h0);
        i_flush = 1'b1;
        drive(2'd0, 32'h33, 6'd1, 5'd3);
        tick();
        chk("fl_valid", 32'(o_valid), 32'h0);
        chk("fl_ready", 32'(o_ready), 32'h1);
        i_flush = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b1;
        repeat (3) tick();
        chk("fl_nothing_after", 32'(o_valid), 32'h0);

`ifdef SHIFT_EXEC_STALL_CNT_EN
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        i_ready = 1'b0;
        drive(2'd1, 32'h80, 6'd3, 5'd1);
        tick();
        i_valid = 1'b0;
        repeat (5) tick();
        chk("stall_five", o_stall_cnt, 32'd5);
        i_flush = 1'b1;
        i_ready = 1'b1;
        tick();
        i_flush = 1'b0;
        chk("stall_after_flush", o_stall_cnt, 32'd5);
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        chk("stall_after_rst", o_stall_cnt, 32'd0);
`endif

        // Randomized traffic against the model
        repeat (3000) begin
            i_rst    = ($urandom_range(0, 199) == 0);
            i_flush  = ($urandom_range(0, 29) == 0);
            i_valid  = ($urandom_range(0, 9) < 7);
            i_ready  = ($urandom_range(0, 9) < 6);
            i_op     = 2'($urandom_range(0, 3));
            i_data   = $urandom;
            i_amount = 6'($urandom_range(0, 63));
            i_rd     = RD_W'($urandom_range(0, (1 << RD_W) - 1));
            tick();
        end

        i_rst = 1'b0;
        i_flush = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b1;
        repeat (3) tick();
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_exec_stage.md
SHIFT_EXEC_STAGE -- requirements
Module: shift_exec_stage

Interface
REQ-001 Parameter RD_W, default 5: destination-register tag width.
REQ-002 i_clk  input  1  clock; all state updates on rising edge.
REQ-003 i_rst  input  1  reset, synchronous, active-high.
REQ-004 i_flush  input  1  synchronous pipeline flush.
REQ-005 i_valid  input  1  upstream operation valid.
REQ-006 o_ready  output  1  stage can accept an operation.
REQ-007 i_op  input  2  00 SLL, 01 SRL, 10 SRA, 11 reserved.
REQ-008 i_data  input  32  operand to shift.
REQ-009 i_amount  input  6  shift amount from the register file or immediate.
REQ-010 i_rd  input  RD_W  destination tag.
REQ-011 o_valid  output  1  result valid.
REQ-012 i_ready  input  1  downstream accepts the result.
REQ-013 o_data  output  32  shifted result.
REQ-014 o_rd  output  RD_W  destination tag of the result.
REQ-015 o_illegal  output  1  result came from a reserved op.

Function
REQ-016 An upstream transfer occurs when i_valid && o_ready; a downstream transfer occurs when o_valid && i_ready.
REQ-017 The effective amount is {1'b0, i_amount[4:0]}; i_amount[5] is ignored.
REQ-018 SLL: logical left shift; SRL: zero-filled right shift; SRA: sign-filled right shift (bit 31 replicated).
REQ-019 Reserved op: o_data = 0, o_illegal = 1, o_rd = i_rd; the operation still completes as a normal transfer.
REQ-020 Latency: a result accepted in cycle N is presented on o_valid/o_data in cycle N+1.
REQ-021 Output buffering is a 2-entry skid buffer with states EMPTY, ONE and FULL.
REQ-022 EMPTY to ONE on an upstream transfer.
REQ-023 ONE to FULL on an upstream transfer without a downstream transfer.
REQ-024 ONE to EMPTY on a downstream transfer without an upstream transfer.
REQ-025 ONE stays ONE when an upstream and a downstream transfer happen in the same cycle.
REQ-026 FULL to ONE on a downstream transfer.
REQ-027 o_ready is a register output, equal to (state != FULL), with no combinational path from i_ready.
REQ-028 Results leave in strict FIFO order.
REQ-029 Output fields are stable while o_valid && !i_ready.
REQ-030 i_flush discards all entries and the same-cycle upstream operation, giving state EMPTY next cycle; i_flush wins over all simultaneous events.
REQ-031 o_valid = (state != EMPTY); o_data, o_rd and o_illegal show the oldest entry and are 0 when EMPTY.

Reset
REQ-032 On i_rst: state EMPTY, o_valid 0, o_ready 1, o_data 0, o_rd 0, o_illegal 0.
REQ-033 If i_rst asserts mid-operation, all buffered entries are discarded.
REQ-034 i_rst has priority over i_flush and all handshakes.

Configuration
REQ-035 With macro SHIFT_EXEC_STALL_CNT_EN defined, output o_stall_cnt [31:0] exists.
REQ-036 o_stall_cnt counts cycles where o_valid && !i_ready, saturates at 32'hFFFFFFFF, and is cleared by i_rst but not by i_flush.
REQ-037 Without SHIFT_EXEC_STALL_CNT_EN, neither the port nor the counter logic exists and all other behaviour is identical.

Structure
REQ-038 A shared package holds the shift-op enum (SLL, SRL, SRA, RSVD) and the skid-state enum.
REQ-039 The existing shifter module is instantiated twice as sub-modules:
- left instance: shift_dir = 0
- right instance: shift_dir = 1, with i_sext = (op == SRA)

Verification
REQ-040 SLL, data 32'h0A0A0A0A, amount 4, i_ready=1 -> next cycle o_valid=1, o_data=32'hA0A0A0A0.
REQ-041 SRA, data 32'hFA0A0A0A, amount 4 -> 32'hFFA0A0A0; SRL with the same inputs -> 32'h0FA0A0A0.
REQ-042 SLL, data 32'h00000001, amount 6'd33 -> 32'h00000002 (bit 5 ignored); op 11 -> o_data=0, o_illegal=1.
REQ-043 Hold i_ready=0 and issue 3 ops back-to-back -> o_ready drops after 2 accepts; release i_ready -> results 1, 2, 3 appear in order with no loss or duplication.
REQ-044 FULL state with i_flush=1 and i_valid=1 -> next cycle o_valid=0, o_ready=1, and nothing is later emitted.
REQ-045 With SHIFT_EXEC_STALL_CNT_EN defined, 5 stalled cycles -> o_stall_cnt=5; after i_flush the count is still 5; after i_rst it is 0.
